// File: rtl/core_spi_pkg.sv
// Shared definitions for the SPI master slice: FSM encoding, SPI mode
// constants and the transition selectors used by edge_idfr.
package core_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XFER = 3'd1,
        ST_TAIL = 3'd2,
        ST_LAT  = 3'd3,
        ST_DONE = 3'd4
    } spi_state_e;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam string EDGE_POS  = "pos";
    localparam string EDGE_NEG  = "neg";
    localparam string EDGE_BOTH = "both";

endpackage

// File: rtl/edge_idfr.sv
// Transition detector: dout is high for the cycle in which din makes the
// transition selected by TYPE, relative to its value on the previous clock.
module edge_idfr
    import core_spi_pkg::*;
#(
    parameter string TYPE = EDGE_POS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic prev_r;

    // previous sample of din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= din;
        end
    end

    generate
        if (TYPE == EDGE_NEG) begin : g_neg
            assign dout = ~din & prev_r;
        end else if (TYPE == EDGE_BOTH) begin : g_both
            assign dout = din ^ prev_r;
        end else begin : g_pos
            assign dout = din & ~prev_r;
        end
    endgenerate

endmodule

// File: rtl/core_spi_master.sv
// SPI master with programmable mode, SCLK divider, word length, MISO sample
// latency and optional 3-wire turnaround.
module core_spi_master
    import core_spi_pkg::*;
#(
    parameter int W_DAT = 32,
    parameter int W_CNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_DAT-1:0] dat_mosi,
    output logic [W_DAT-1:0] dat_miso,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [W_CNT-1:0] clk_div,
    input  logic [W_CNT-1:0] bit_cnt,
    input  logic             f_snd,
    output logic             f_fin,
    input  logic [W_CNT-1:0] miso_ltn,
    input  logic [W_CNT-1:0] mosi_cnt,
    output logic             bus_dir,
    output logic             csb,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    typedef logic [W_CNT:0] cnt_t;

    function automatic cnt_t norm_div(input logic [W_CNT-1:0] d);
        if (d == {W_CNT{1'b0}}) return cnt_t'(1);
        else return {1'b0, d};
    endfunction

    function automatic cnt_t clamp_bits(input logic [W_CNT-1:0] b);
        if (b == {W_CNT{1'b0}}) return cnt_t'(1);
        else if (int'(b) > W_DAT) return cnt_t'(W_DAT);
        else return {1'b0, b};
    endfunction

    spi_state_e       state_r, state_s;
    logic             start_s, tick_s, edge_s, shift_s, turn_s, release_s;
    cnt_t             h_r, n_r, m_r, ltn_r, hcnt_r, ecnt_r, lcnt_r;
    cnt_t             n2_s, idx_s, n_new_s;
    cnt_t             rx_dly_r, rx_hcnt_r, rx_ecnt_r;
    logic             rx_act_r, cpol_r, cpha_r, three_wire_r;
    logic             csb_r, sclk_r, mosi_r, bus_dir_r, f_fin_r;
    logic [W_DAT-1:0] tx_sh_r, rx_sh_r, aligned_s;

    edge_idfr #(.TYPE(EDGE_POS)) u_start (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (f_snd),
        .dout (start_s)
    );

    assign n_new_s   = clamp_bits(bit_cnt);
    assign aligned_s = dat_mosi << (W_DAT - int'(n_new_s));
    assign tick_s    = (hcnt_r == h_r);
    assign n2_s      = n_r << 1;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (start_s) state_s = ST_XFER; else state_s = ST_IDLE;
            ST_XFER: if (tick_s && (ecnt_r + cnt_t'(1) == n2_s)) state_s = ST_TAIL; else state_s = ST_XFER;
            ST_TAIL: begin
                if (tick_s) state_s = (ltn_r == cnt_t'(0)) ? ST_DONE : ST_LAT;
                else state_s = ST_TAIL;
            end
            ST_LAT:  if (lcnt_r == ltn_r) state_s = ST_DONE; else state_s = ST_LAT;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output strobes; idx_s is the bit index a shift edge would put on mosi
    always_comb begin
        edge_s    = (state_r == ST_XFER) && tick_s;
        shift_s   = edge_s && (ecnt_r[0] != cpha_r);
        idx_s     = cpha_r ? (ecnt_r >> 1) : ((ecnt_r + cnt_t'(1)) >> 1);
        turn_s    = shift_s && three_wire_r && (idx_s == m_r);
        release_s = (state_r == ST_TAIL) && tick_s;
    end

    // transmit side: bus pins, timing counters, latched configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_r <= 1'b1; sclk_r <= 1'b0; mosi_r <= 1'b0; bus_dir_r <= 1'b1; f_fin_r <= 1'b0;
            cpol_r <= 1'b0; cpha_r <= 1'b0; three_wire_r <= 1'b0;
            h_r <= cnt_t'(1); n_r <= cnt_t'(1); m_r <= cnt_t'(0); ltn_r <= cnt_t'(0);
            hcnt_r <= cnt_t'(0); ecnt_r <= cnt_t'(0); lcnt_r <= cnt_t'(0);
            tx_sh_r <= {W_DAT{1'b0}};
        end else begin
            f_fin_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    sclk_r <= cpol;
                    if (start_s) begin
                        cpol_r       <= cpol;
                        cpha_r       <= cpha;
                        h_r          <= norm_div(clk_div);
                        n_r          <= n_new_s;
                        m_r          <= {1'b0, mosi_cnt};
                        ltn_r        <= {1'b0, miso_ltn};
                        three_wire_r <= (mosi_cnt != {W_CNT{1'b0}}) && ({1'b0, mosi_cnt} < n_new_s);
                        hcnt_r       <= cnt_t'(1);
                        ecnt_r       <= cnt_t'(0);
                        csb_r        <= 1'b0;
                        mosi_r       <= aligned_s[W_DAT-1];
                        // cpha=1 re-drives bit 0 on the first leading edge
                        tx_sh_r      <= cpha ? aligned_s : {aligned_s[W_DAT-2:0], 1'b0};
                    end
                end
                ST_XFER: begin
                    if (tick_s) begin
                        hcnt_r <= cnt_t'(1);
                        ecnt_r <= ecnt_r + cnt_t'(1);
                        sclk_r <= ~sclk_r;
                    end else begin
                        hcnt_r <= hcnt_r + cnt_t'(1);
                    end
                    if (shift_s) begin
                        tx_sh_r <= {tx_sh_r[W_DAT-2:0], 1'b0};
                        mosi_r  <= (turn_s || !bus_dir_r) ? 1'b0 : tx_sh_r[W_DAT-1];
                    end
                    if (turn_s) bus_dir_r <= 1'b0;
                end
                ST_TAIL: begin
                    if (release_s) begin
                        hcnt_r    <= cnt_t'(1);
                        lcnt_r    <= cnt_t'(1);
                        csb_r     <= 1'b1;
                        sclk_r    <= cpol_r;
                        bus_dir_r <= 1'b1;
                        mosi_r    <= 1'b0;
                    end else begin
                        hcnt_r <= hcnt_r + cnt_t'(1);
                    end
                end
                ST_LAT:  lcnt_r <= lcnt_r + cnt_t'(1);
                ST_DONE: lcnt_r <= cnt_t'(0);
                default: lcnt_r <= cnt_t'(0);
            endcase
        end
    end

    // receive side: a copy of the edge timeline delayed by miso_ltn cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_act_r <= 1'b0; rx_dly_r <= cnt_t'(0); rx_hcnt_r <= cnt_t'(0); rx_ecnt_r <= cnt_t'(0);
            rx_sh_r  <= {W_DAT{1'b0}};
        end else if ((state_r == ST_IDLE) && start_s) begin
            rx_act_r <= 1'b1; rx_dly_r <= {1'b0, miso_ltn}; rx_hcnt_r <= cnt_t'(0); rx_ecnt_r <= cnt_t'(0);
            rx_sh_r  <= {W_DAT{1'b0}};
        end else if (rx_act_r) begin
            if (rx_dly_r != cnt_t'(0)) begin
                rx_dly_r <= rx_dly_r - cnt_t'(1);
            end else if (rx_hcnt_r == h_r) begin
                rx_hcnt_r <= cnt_t'(1);
                rx_ecnt_r <= rx_ecnt_r + cnt_t'(1);
                if (rx_ecnt_r[0] == cpha_r) rx_sh_r <= {rx_sh_r[W_DAT-2:0], miso};
                if (rx_ecnt_r + cnt_t'(1) == n2_s) rx_act_r <= 1'b0;
            end else begin
                rx_hcnt_r <= rx_hcnt_r + cnt_t'(1);
            end
        end
    end

    assign csb      = csb_r;
    assign sclk     = sclk_r;
    assign mosi     = mosi_r;
    assign bus_dir  = bus_dir_r;
    assign f_fin    = f_fin_r;
    assign dat_miso = rx_sh_r;

endmodule

// File: tb/tb_core_spi_master.sv
// Directed self-checking bench for core_spi_master and edge_idfr.
module tb_core_spi_master;
    import core_spi_pkg::*;

    localparam int W_DAT = 32;
    localparam int W_CNT = 8;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic [W_DAT-1:0] dat_mosi = '0, dat_miso;
    logic             cpol = 1'b0, cpha = 1'b0, f_snd = 1'b0, f_fin;
    logic [W_CNT-1:0] clk_div = '0, bit_cnt = '0, miso_ltn = '0, mosi_cnt = '0;
    logic             bus_dir, csb, sclk, mosi, miso;
    logic [1:0]       miso_sel = 2'd0;
    logic [2:0]       dly_r = 3'b000;
    logic             e_din = 1'b0, e_pos, e_neg, e_both;

    int n_chk = 0, n_pass = 0;
    int res_cyc, res_rise, res_dir_fall, res_bad;
    logic [31:0] res_samp;
    logic res_got, res_sclk, res_csb, res_dir;

    core_spi_master #(.W_DAT(W_DAT), .W_CNT(W_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .dat_mosi(dat_mosi), .dat_miso(dat_miso),
        .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .bit_cnt(bit_cnt),
        .f_snd(f_snd), .f_fin(f_fin), .miso_ltn(miso_ltn), .mosi_cnt(mosi_cnt),
        .bus_dir(bus_dir), .csb(csb), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    edge_idfr #(.TYPE(EDGE_POS))  u_pos  (.clk(clk), .rst_n(rst_n), .din(e_din), .dout(e_pos));
    edge_idfr #(.TYPE(EDGE_NEG))  u_neg  (.clk(clk), .rst_n(rst_n), .din(e_din), .dout(e_neg));
    edge_idfr #(.TYPE(EDGE_BOTH)) u_both (.clk(clk), .rst_n(rst_n), .din(e_din), .dout(e_both));

    always #5 clk = ~clk;

    // slave model: loopback, tied high, mosi delayed 3 cycles, or tied low
    always @(posedge clk) dly_r <= {dly_r[1:0], mosi};
    always_comb begin
        case (miso_sel)
            2'd0:    miso = mosi;
            2'd1:    miso = 1'b1;
            2'd2:    miso = dly_r[2];
            default: miso = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // runs one transfer; res_cyc counts cycles from f_snd (cycle t) to f_fin
    task automatic run_xfer(input string tag, input logic pol, input logic pha, input int h,
                            input int n, input logic [31:0] d, input int ltn, input int mc,
                            input int rep);
        logic prev_sclk;
        cpol = pol; cpha = pha; clk_div = W_CNT'(h); bit_cnt = W_CNT'(n);
        dat_mosi = d; miso_ltn = W_CNT'(ltn); mosi_cnt = W_CNT'(mc);
        repeat (2) @(posedge clk);
        #1 f_snd = 1'b1;
        prev_sclk = sclk;
        res_cyc = 0; res_rise = 0; res_dir_fall = -1; res_bad = 0; res_samp = '0; res_got = 1'b0;
        while (!res_got && res_cyc < 5000) begin
            @(posedge clk); #1;
            res_cyc++;
            f_snd = (res_cyc == rep);
            if (sclk && !prev_sclk) begin
                res_rise++;
                res_samp = {res_samp[30:0], mosi};
            end
            prev_sclk = sclk;
            if (!bus_dir && res_dir_fall < 0) res_dir_fall = res_cyc;
            if (!bus_dir && mosi) res_bad = 1;
            if (f_fin) begin
                res_got = 1'b1; res_sclk = sclk; res_csb = csb; res_dir = bus_dir;
            end
        end
        f_snd = 1'b0;
        check({tag, "_done"}, {31'd0, res_got}, 32'd1);
    endtask

    initial begin
        logic [3:0] pat, pos_v, neg_v, both_v;
        int fin_seen;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_pins", {27'd0, csb, sclk, mosi, bus_dir, f_fin}, 32'b10010);
        check("rst_miso", dat_miso, 32'h0);
        rst_n = 1'b1;

        // mode 3 loopback, H=16, N=24
        miso_sel = 2'd0;
        run_xfer("m3", 1'b1, 1'b1, 16, 24, 32'hA5C3F0, 0, 0, -1);
        check("m3_cyc", res_cyc, 32'd785);
        check("m3_rise", res_rise, 32'd24);
        check("m3_mosi", res_samp, 32'hA5C3F0);
        check("m3_miso", dat_miso, 32'hA5C3F0);
        check("m3_idle", {30'd0, res_csb, res_sclk}, 32'b11);
        check("m3_dir", res_dir_fall, 32'hFFFF_FFFF);

        // mode 0, H=1, N=8, miso high; mosi_cnt=N keeps 4-wire behaviour
        miso_sel = 2'd1;
        run_xfer("m0", 1'b0, 1'b0, 1, 8, 32'h81, 0, 8, -1);
        check("m0_mosi", res_samp, 32'h81);
        check("m0_miso", dat_miso, 32'hFF);
        check("m0_cyc", res_cyc, 32'd18);
        check("m0_dir", res_dir_fall, 32'hFFFF_FFFF);

        // MISO latency compensation with a 3-cycle slave delay
        miso_sel = 2'd2;
        run_xfer("lt0", 1'b0, 1'b0, 4, 8, 32'h6B, 0, 0, -1);
        check("lt0_cyc", res_cyc, 32'd69);
        check("lt0_miso", dat_miso, 32'h6B);
        run_xfer("lt3", 1'b0, 1'b0, 4, 8, 32'h6B, 3, 0, -1);
        check("lt3_cyc", res_cyc, 32'd72);
        check("lt3_miso", dat_miso, 32'h6B);

        // 3-wire, turnaround after 8 of 16 bits
        miso_sel = 2'd1;
        run_xfer("w3", 1'b0, 1'b0, 2, 16, 32'hFFFF, 0, 8, -1);
        check("w3_fall", res_dir_fall, 32'd33);
        check("w3_mosi", res_samp, 32'hFF00);
        check("w3_quiet", res_bad, 32'd0);
        check("w3_dir_end", {31'd0, res_dir}, 32'd1);
        check("w3_cyc", res_cyc, 32'd67);

        // repeated f_snd mid-transfer is ignored
        miso_sel = 2'd0;
        run_xfer("rep", 1'b0, 1'b0, 4, 8, 32'h3C, 0, 0, 10);
        check("rep_cyc", res_cyc, 32'd69);
        check("rep_miso", dat_miso, 32'h3C);

        // reset mid-transfer aborts with no f_fin
        miso_sel = 2'd1;
        cpol = 1'b1; cpha = 1'b0; clk_div = 8'd4; bit_cnt = 8'd8; dat_mosi = 32'hF0;
        miso_ltn = 8'd0; mosi_cnt = 8'd0;
        repeat (2) @(posedge clk);
        #1 f_snd = 1'b1;
        @(posedge clk); #1 f_snd = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("abt_busy", {30'd0, csb, (dat_miso != 32'h0)}, 32'b01);
        rst_n = 1'b0;
        #1;
        check("abt_pins", {27'd0, csb, sclk, mosi, bus_dir, f_fin}, 32'b10010);
        check("abt_miso", dat_miso, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        fin_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (f_fin) fin_seen++;
        end
        check("abt_nofin", fin_seen, 32'd0);
        check("abt_csb", {31'd0, csb}, 32'd1);

        // edge_idfr on din pattern 0,1,1,0
        pat = 4'b0110; pos_v = '0; neg_v = '0; both_v = '0;
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk); #1 e_din = pat[i];
            #1;
            pos_v  = {pos_v[2:0], e_pos};
            neg_v  = {neg_v[2:0], e_neg};
            both_v = {both_v[2:0], e_both};
        end
        check("edge_pos", {28'd0, pos_v}, 32'b0100);
        check("edge_neg", {28'd0, neg_v}, 32'b0001);
        check("edge_both", {28'd0, both_v}, 32'b0101);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
